// File: rtl/p65c816_pkg.sv
// p65c816_pkg: shared types and stateCtrl codes for the P65C816 microcode sequencer.
package p65c816_pkg;
    typedef enum logic [2:0] {
        INT_NONE  = 3'd0,
        INT_IRQ   = 3'd1,
        INT_NMI   = 3'd2,
        INT_ABORT = 3'd3,
        INT_RESET = 3'd4
    } seq_int_e;
    typedef enum logic [1:0] {RUN, WAIT, STOP} seq_state_e;
    localparam logic [2:0] SC_NEXT    = 3'b000;
    localparam logic [2:0] SC_END     = 3'b001;
    localparam logic [2:0] SC_SKIP_W8 = 3'b010;
    localparam logic [2:0] SC_SKIP_DL = 3'b011;
    localparam logic [2:0] SC_BRANCH  = 3'b100;
    localparam logic [2:0] SC_WAI     = 3'b101;
    localparam logic [2:0] SC_STP     = 3'b110;
    localparam logic [2:0] SC_SKIP_PG = 3'b111;
endpackage

// File: rtl/p65c816_int_latch.sv
// p65c816_int_latch: NMI falling-edge detector and ABORT latch with take/clear handshake.
// ABORT latch is present only when P65C816_ABORT_EN is defined.
module p65c816_int_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic nmi_n,
`ifdef P65C816_ABORT_EN
    input  logic abort_n,
    input  logic take_abort,
`endif
    input  logic take_nmi,
    output logic nmi_pend,
    output logic abort_pend
);
    logic nmi_prev;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nmi_prev <= 1'b1;
            nmi_pend <= 1'b0;
        end else if (ce) begin
            nmi_prev <= nmi_n;
            nmi_pend <= (nmi_prev & ~nmi_n) | (nmi_pend & ~take_nmi);
        end
    end
`ifdef P65C816_ABORT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) abort_pend <= 1'b0;
        else if (ce) abort_pend <= ~abort_n | (abort_pend & ~take_abort);
    end
`else
    assign abort_pend = 1'b0;
`endif
endmodule

// File: rtl/p65c816_mcode_seq.sv
// p65c816_mcode_seq: IR/MC microcode sequencer with interrupt injection, WAI and STP.
// Define P65C816_ABORT_EN to add the ABORT_N input and INT_ABORT entries.
module p65c816_mcode_seq
    import p65c816_pkg::*;
#(
    parameter int         MC_W   = 3,
    parameter logic [7:0] IR_INT = 8'h00
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic            rdy_in,
    input  logic [7:0]      d_in,
    input  logic [2:0]      state_ctrl,
    input  logic            w16,
    input  logic            dl_zero,
    input  logic            br_taken,
    input  logic            pg_cross,
    input  logic            i_flag,
    input  logic            irq_n,
    input  logic            nmi_n,
`ifdef P65C816_ABORT_EN
    input  logic            abort_n,
`endif
    output logic [7:0]      ir,
    output logic [MC_W-1:0] mc,
    output logic [2:0]      int_type,
    output logic            sync,
    output logic            last_cycle,
    output logic            rdy_out,
    output logic            stopped
);
    seq_state_e state, state_n;
    seq_int_e   int_q, int_n;
    logic [7:0]    ir_n;
    logic [MC_W:0] tgt;
    logic adv, fetch, rst_fetch, inc2, step_end, halt, take_nmi, nmi_pend, abort_pend;
`ifdef P65C816_ABORT_EN
    logic take_abort;
    assign take_abort = fetch & (int_n == INT_ABORT);
`endif

    p65c816_int_latch u_lat (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .nmi_n     (nmi_n),
`ifdef P65C816_ABORT_EN
        .abort_n   (abort_n),
        .take_abort(take_abort),
`endif
        .take_nmi  (take_nmi),
        .nmi_pend  (nmi_pend),
        .abort_pend(abort_pend)
    );

    always_comb begin
        adv   = ce & rdy_in & (state == RUN);
        fetch = adv & (mc == '0);
        int_n = rst_fetch ? INT_RESET :
                abort_pend ? INT_ABORT :
                nmi_pend ? INT_NMI :
                (~irq_n & ~i_flag) ? INT_IRQ : INT_NONE;
        ir_n     = (int_n == INT_NONE) ? d_in : IR_INT;
        take_nmi = fetch & (int_n == INT_NMI);
        inc2 = (state_ctrl == SC_SKIP_W8 & ~w16) | (state_ctrl == SC_SKIP_DL & dl_zero) |
               (state_ctrl == SC_SKIP_PG & ~pg_cross);
        tgt  = {1'b0, mc} + {{(MC_W-1){1'b0}}, inc2, ~inc2};
        // a target past MC_MAX ends the instruction instead of wrapping
        step_end = (state_ctrl == SC_END) | (state_ctrl == SC_BRANCH & ~br_taken) | tgt[MC_W];
        halt     = (state_ctrl == SC_WAI) | (state_ctrl == SC_STP);
        state_n  = (adv & mc != '0 & state_ctrl == SC_WAI) ? WAIT :
                   (adv & mc != '0 & state_ctrl == SC_STP) ? STOP :
                   (ce & state == WAIT & (nmi_pend | ~irq_n | abort_pend)) ? RUN : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir        <= IR_INT;
            mc        <= '0;
            int_q     <= INT_RESET;
            rst_fetch <= 1'b1;
        end else if (fetch) begin
            ir        <= ir_n;
            int_q     <= int_n;
            rst_fetch <= 1'b0;
            mc        <= MC_W'(1);
        end else if (adv) begin
            mc <= (halt | step_end) ? '0 : tgt[MC_W-1:0];
        end
    end

    assign int_type   = int_q;
    assign sync       = (mc == '0);
    assign last_cycle = (mc != '0) & step_end & ~halt;
    assign rdy_out    = (state != WAIT);
    assign stopped    = (state == STOP);
endmodule

// File: tb/tb_p65c816_mcode_seq.sv
// tb_p65c816_mcode_seq: directed-vector bench for the microcode sequencer.
module tb_p65c816_mcode_seq;
    import p65c816_pkg::*;
    logic       clk, rst_n, ce, rdy_in, w16, dl_zero, br_taken, pg_cross, i_flag, irq_n, nmi_n, abort_n;
    logic [7:0] d_in, ir;
    logic [2:0] state_ctrl, mc, int_type;
    logic       sync, last_cycle, rdy_out, stopped;
    int checks = 0;
    int errors = 0;

    p65c816_mcode_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .rdy_in    (rdy_in),
        .d_in      (d_in),
        .state_ctrl(state_ctrl),
        .w16       (w16),
        .dl_zero   (dl_zero),
        .br_taken  (br_taken),
        .pg_cross  (pg_cross),
        .i_flag    (i_flag),
        .irq_n     (irq_n),
        .nmi_n     (nmi_n),
`ifdef P65C816_ABORT_EN
        .abort_n   (abort_n),
`endif
        .ir        (ir),
        .mc        (mc),
        .int_type  (int_type),
        .sync      (sync),
        .last_cycle(last_cycle),
        .rdy_out   (rdy_out),
        .stopped   (stopped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; ce = 1; rdy_in = 1; d_in = 8'h00; state_ctrl = SC_NEXT;
        w16 = 0; dl_zero = 0; br_taken = 0; pg_cross = 0;
        i_flag = 1; irq_n = 1; nmi_n = 1; abort_n = 1;
        tick; tick;
        chk("rst_ir", ir, 8'h00);
        chk("rst_mc", mc, 0);
        chk("rst_int", int_type, 4);
        chk("rst_rdy", rdy_out, 1);
        chk("rst_stop", stopped, 0);
        chk("rst_sync", sync, 1);
        rst_n = 1; d_in = 8'hFF; tick;
        chk("rfetch_ir", ir, 8'h00);
        chk("rfetch_int", int_type, 4);
        chk("rfetch_mc", mc, 1);
        state_ctrl = SC_END; #1;
        chk("rseq_last", last_cycle, 1);
        tick; chk("rseq_end_mc", mc, 0);
        d_in = 8'hA9; state_ctrl = SC_NEXT; tick;
        chk("a9_ir", ir, 8'hA9);
        chk("a9_int", int_type, 0);
        chk("a9_mc", mc, 1);
        chk("a9_sync", sync, 0);
        #1 chk("next_last", last_cycle, 0);
        tick; chk("next_mc", mc, 2);
        state_ctrl = SC_SKIP_W8; w16 = 0; #1;
        chk("w8_last", last_cycle, 0);
        tick; chk("w8_mc", mc, 4);
        state_ctrl = SC_END; #1;
        chk("end_last", last_cycle, 1);
        tick; chk("end_mc", mc, 0);
        d_in = 8'hEA; state_ctrl = SC_NEXT; tick;
        tick; chk("w16_a_mc", mc, 2);
        state_ctrl = SC_SKIP_W8; w16 = 1; tick;
        chk("w16_b_mc", mc, 3);
        state_ctrl = SC_END; tick;
        chk("w16_c_mc", mc, 0);
        ce = 0; state_ctrl = SC_NEXT; d_in = 8'h11; tick;
        chk("ce0_mc", mc, 0);
        chk("ce0_ir", ir, 8'hEA);
        ce = 1; d_in = 8'hAD; tick;
        chk("stall_ir0", ir, 8'hAD);
        tick; chk("stall_mc0", mc, 2);
        rdy_in = 0; nmi_n = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stall_mc", mc, 2);
            chk("stall_ir", ir, 8'hAD);
        end
        rdy_in = 1; state_ctrl = SC_END; tick;
        chk("stall_end_mc", mc, 0);
        d_in = 8'h55; tick;
        chk("nmi_ir", ir, 8'h00);
        chk("nmi_int", int_type, 2);
        chk("nmi_mc", mc, 1);
        nmi_n = 1; tick;
        d_in = 8'h77; tick;
        chk("nmi_clr_int", int_type, 0);
        chk("nmi_clr_ir", ir, 8'h77);
        tick;
        irq_n = 0; i_flag = 1; d_in = 8'h42; tick;
        chk("irq_mask_ir", ir, 8'h42);
        chk("irq_mask_int", int_type, 0);
        tick;
        i_flag = 0; d_in = 8'h43; tick;
        chk("irq_ir", ir, 8'h00);
        chk("irq_int", int_type, 1);
        nmi_n = 0; tick;
        tick;
        chk("nmi_irq_int", int_type, 2);
        nmi_n = 1; irq_n = 1; i_flag = 1; tick;
        d_in = 8'hD0; tick;
        state_ctrl = SC_BRANCH; br_taken = 1; #1;
        chk("brt_last", last_cycle, 0);
        tick; chk("brt_mc", mc, 2);
        state_ctrl = SC_SKIP_PG; pg_cross = 0; tick;
        chk("pg_mc", mc, 4);
        state_ctrl = SC_SKIP_DL; dl_zero = 1; tick;
        chk("dl_mc", mc, 6);
        #1 chk("dl_ovf_last", last_cycle, 1);
        tick; chk("dl_ovf_mc", mc, 0);
        d_in = 8'hD1; tick;
        state_ctrl = SC_BRANCH; br_taken = 0; #1;
        chk("brn_last", last_cycle, 1);
        tick; chk("brn_mc", mc, 0);
        d_in = 8'hCB; tick;
        state_ctrl = SC_WAI; #1;
        chk("wai_last", last_cycle, 0);
        tick;
        chk("wai_rdy", rdy_out, 0);
        chk("wai_mc", mc, 0);
        state_ctrl = SC_NEXT; tick;
        chk("wai_hold", rdy_out, 0);
        irq_n = 0; tick;
        chk("wai_wake", rdy_out, 1);
        d_in = 8'h58; tick;
        chk("wai_fetch_ir", ir, 8'h58);
        chk("wai_fetch_int", int_type, 0);
        irq_n = 1; state_ctrl = SC_END; tick;
        d_in = 8'hDB; tick;
        state_ctrl = SC_STP; #1;
        chk("stp_last", last_cycle, 0);
        tick; chk("stp_stopped", stopped, 1);
        nmi_n = 0; tick;
        irq_n = 0; tick;
        chk("stp_hold", stopped, 1);
        chk("stp_ir", ir, 8'hDB);
        chk("stp_mc", mc, 0);
        rst_n = 0; nmi_n = 1; irq_n = 1; tick;
        chk("stp_rst", stopped, 0);
        chk("stp_rst_ir", ir, 8'h00);
        chk("stp_rst_int", int_type, 4);
        rst_n = 1; state_ctrl = SC_NEXT; tick;
        repeat (6) tick;
        chk("ovf_mc7", mc, 7);
        #1 chk("ovf_last", last_cycle, 1);
        tick; chk("ovf_mc", mc, 0);
        d_in = 8'h60; tick;
        chk("post_rst_int", int_type, 0);
        chk("post_rst_ir", ir, 8'h60);
`ifdef P65C816_ABORT_EN
        state_ctrl = SC_END; tick;
        d_in = 8'h61; tick;
        abort_n = 0; nmi_n = 0; tick;
        abort_n = 1; tick;
        chk("abort_int", int_type, 3);
        chk("abort_ir", ir, 8'h00);
        nmi_n = 1; tick;
        tick;
        chk("abort_nmi_int", int_type, 2);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
